// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mult_div_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_e;

endpackage

// File: rtl/mult_div_if.sv
// Operand/handshake/result bundle between the core pipeline and mult_div_unit.
interface mult_div_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operandA;
  logic [WIDTH-1:0] operandB;
  logic             mtWrite;
  logic             mtSel;
  logic [WIDTH-1:0] mtData;
  logic             ready;
  logic             done;
  logic             divByZero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, operandA, operandB, mtWrite, mtSel, mtData,
    input  ready, done, divByZero, hi, lo
  );

  modport slave (
    input  start, op, operandA, operandB, mtWrite, mtSel, mtData,
    output ready, done, divByZero, hi, lo
  );

endinterface

// File: rtl/mult_div_core.sv
// 64-bit shift/accumulate datapath and iteration counter, one step per cycle.
// The restoring-divide step is only built when DIV_EN is defined.
module mult_div_core
  import mult_div_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
`ifdef DIV_EN
  input  logic               div_mode,
`endif
  input  logic [WIDTH-1:0]   lo_init,
  input  logic [WIDTH-1:0]   addend,
  output logic [2*WIDTH-1:0] acc,
  output logic               last
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   addend_q, addend_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     mul_sum;
`ifdef DIV_EN
  logic [WIDTH:0]     trial;
`endif

  // Multiply: add multiplicand into the upper half, shift right with carry.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, addend_q} : '0);
`ifdef DIV_EN
  // Divide: trial-subtract the divisor from {remainder, next dividend bit}.
  assign trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, addend_q};
`endif

  always_comb begin
    acc_d    = acc_q;
    addend_d = addend_q;
    cnt_d    = cnt_q;
    if (load) begin
      acc_d    = {{WIDTH{1'b0}}, lo_init};
      addend_d = addend;
      cnt_d    = '0;
    end else if (step) begin
      cnt_d = cnt_q + CNT_W'(1);
`ifdef DIV_EN
      if (div_mode) begin
        if (!trial[WIDTH])
          acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else
          acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
      end else begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      end
`else
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      addend_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      addend_q <= addend_d;
      cnt_q    <= cnt_d;
    end
  end

  assign acc  = acc_q;
  assign last = (cnt_q == CNT_W'(ITER - 1));

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers and mthi/mtlo writes.
// Define DIV_EN to build the divider; otherwise divide ops complete at once.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  mult_div_if.slave bus
);
  import mult_div_pkg::*;

  // state | meaning
  // IDLE  | ready for start; mt writes only
  // CALC  | 32 datapath iterations in mult_div_core
  // SIGN  | sign correction, HI/LO write, done pulse

  state_e             state_q;
  logic               ready_q, done_q;
  logic               signed_q, sign_a_q, sign_b_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic [WIDTH-1:0]   a_mag, b_mag, lo_init, addend;
  logic [2*WIDTH-1:0] acc, prod;
  logic               accept, op_signed, op_div, core_last, neg;
`ifdef DIV_EN
  logic               div_q, dbz_q, b_zero_q;
  logic [WIDTH-1:0]   a_raw_q, quot, rem;
`endif

  assign op_signed = ~bus.op[0];
  assign op_div    = bus.op[1];
  assign accept    = (state_q == IDLE) && bus.start && ready_q;

  assign a_mag = (op_signed && bus.operandA[WIDTH-1]) ? -bus.operandA : bus.operandA;
  assign b_mag = (op_signed && bus.operandB[WIDTH-1]) ? -bus.operandB : bus.operandB;

`ifdef DIV_EN
  assign lo_init = op_div ? a_mag : b_mag;
  assign addend  = op_div ? b_mag : a_mag;
`else
  assign lo_init = b_mag;
  assign addend  = a_mag;
`endif

  mult_div_core u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .step     (state_q == CALC),
`ifdef DIV_EN
    .div_mode (div_q),
`endif
    .lo_init  (lo_init),
    .addend   (addend),
    .acc      (acc),
    .last     (core_last)
  );

  assign neg  = signed_q & (sign_a_q ^ sign_b_q);
  assign prod = neg ? -acc : acc;
`ifdef DIV_EN
  assign quot = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem  = (signed_q && sign_a_q) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
`endif

  always_comb begin
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
`ifdef DIV_EN
    if (div_q) begin
      if (b_zero_q) begin
        res_hi = a_raw_q;
        res_lo = '1;
      end else begin
        res_hi = rem;
        res_lo = quot;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      signed_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef DIV_EN
      div_q    <= 1'b0;
      dbz_q    <= 1'b0;
      b_zero_q <= 1'b0;
      a_raw_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef DIV_EN
      dbz_q  <= 1'b0;
`endif
      if (bus.mtWrite) begin
        if (bus.mtSel) hi_q <= bus.mtData;
        else           lo_q <= bus.mtData;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            signed_q <= op_signed;
            sign_a_q <= bus.operandA[WIDTH-1];
            sign_b_q <= bus.operandB[WIDTH-1];
`ifdef DIV_EN
            div_q    <= op_div;
            b_zero_q <= (bus.operandB == '0);
            a_raw_q  <= bus.operandA;
            state_q  <= CALC;
            ready_q  <= 1'b0;
`else
            if (op_div) begin
              done_q <= 1'b1;
            end else begin
              state_q <= CALC;
              ready_q <= 1'b0;
            end
`endif
          end
        end
        CALC: begin
          if (core_last) state_q <= SIGN;
        end
        SIGN: begin
          // Result write is last so it wins over a same-edge mt write.
          hi_q    <= res_hi;
          lo_q    <= res_lo;
          done_q  <= 1'b1;
`ifdef DIV_EN
          dbz_q   <= div_q & b_zero_q;
`endif
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
`ifdef DIV_EN
  assign bus.divByZero = dbz_q;
`else
  assign bus.divByZero = 1'b0;
`endif

endmodule
